// File: rtl/dm_dmi_host.sv
// Host-side DMI transaction engine: turns host READ/WRITE/NOP commands into DMI
// request/response handshakes, with a sticky error status and a request timeout.
module dm_dmi_host #(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [6:0]  cmd_addr_i,
    input  logic [1:0]  cmd_op_i,
    input  logic [31:0] cmd_data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic [1:0]  rsp_status_o,
    output logic        dmi_req_valid_o,
    input  logic        dmi_req_ready_i,
    output logic [40:0] dmi_req_o,
    input  logic        dmi_resp_valid_i,
    output logic        dmi_resp_ready_o,
    input  logic [33:0] dmi_resp_i,
    input  logic        dmireset_i,
    input  logic        dmihardreset_i,
    output logic [1:0]  dmistat_o,
    output logic        busy_o
);

    localparam logic [1:0] OP_NOP     = 2'd0;
    localparam logic [1:0] OP_READ    = 2'd1;
    localparam logic [1:0] OP_WRITE   = 2'd2;
    localparam logic [1:0] ST_SUCCESS = 2'd0;
    localparam logic [1:0] ST_ERR     = 2'd2;

    localparam int unsigned CntW = (TimeoutCycles > 32'd0) ? $clog2(TimeoutCycles + 32'd1) : 1;
    localparam logic [CntW-1:0] CntMax   = {CntW{1'b1}};
    localparam logic [CntW-1:0] CntLimit = CntW'(TimeoutCycles);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;

    state_t          state_r, state_s;
    logic [6:0]      addr_r;
    logic [1:0]      op_r;
    logic [31:0]     wdata_r;
    logic [31:0]     rdata_r, rdata_s;
    logic [31:0]     rsp_data_r, rsp_data_s;
    logic [1:0]      rsp_status_r, rsp_status_s;
    logic [1:0]      dmistat_r, dmistat_s;
    logic [CntW-1:0] cnt_r, cnt_s, cnt_inc_s;
    logic            latch_s;
    logic            set_sticky_s;
    logic [1:0]      sticky_val_s;
    logic [1:0]      resp_st_s;
    logic            timeout_s;

    // Counter saturates at its all-ones value so a disabled timeout never wraps.
    always_comb begin
        if (cnt_r == CntMax) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + {{(CntW-1){1'b0}}, 1'b1};
        end
        timeout_s = (TimeoutCycles != 32'd0) && (cnt_r >= CntLimit);
        if (dmi_resp_i[1:0] == 2'd1) begin
            resp_st_s = ST_ERR;
        end else begin
            resp_st_s = dmi_resp_i[1:0];
        end
    end

    // Next-state, response and sticky-status decode.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        rdata_s      = rdata_r;
        rsp_data_s   = rsp_data_r;
        rsp_status_s = rsp_status_r;
        latch_s      = 1'b0;
        set_sticky_s = 1'b0;
        sticky_val_s = ST_SUCCESS;
        dmistat_s    = dmistat_r;
        case (state_r)
            IDLE: begin
                if (cmd_valid_i) begin
                    if (dmistat_r != ST_SUCCESS) begin
                        state_s      = RSP;
                        rsp_status_s = dmistat_r;
                        rsp_data_s   = 32'h0000_0000;
                    end else begin
                        case (cmd_op_i)
                            OP_NOP: begin
                                state_s      = RSP;
                                rsp_status_s = ST_SUCCESS;
                                rsp_data_s   = rdata_r;
                            end
                            OP_READ, OP_WRITE: begin
                                state_s = REQ;
                                latch_s = 1'b1;
                                cnt_s   = {CntW{1'b0}};
                            end
                            default: begin
                                state_s      = RSP;
                                rsp_status_s = ST_ERR;
                                rsp_data_s   = 32'h0000_0000;
                                set_sticky_s = 1'b1;
                                sticky_val_s = ST_ERR;
                            end
                        endcase
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                cnt_s = cnt_inc_s;
                if (dmi_req_ready_i) begin
                    state_s = WAIT;
                end else if (timeout_s) begin
                    state_s      = RSP;
                    rsp_status_s = ST_ERR;
                    rsp_data_s   = 32'h0000_0000;
                    set_sticky_s = 1'b1;
                    sticky_val_s = ST_ERR;
                end else begin
                    state_s = REQ;
                end
            end
            WAIT: begin
                cnt_s = cnt_inc_s;
                // A response landing on the timeout cycle still wins; the DM has already handed it over.
                if (dmi_resp_valid_i) begin
                    state_s      = RSP;
                    rsp_status_s = resp_st_s;
                    rsp_data_s   = dmi_resp_i[33:2];
                    if (op_r == OP_READ) begin
                        rdata_s = dmi_resp_i[33:2];
                    end else begin
                        rdata_s = rdata_r;
                    end
                    if (resp_st_s != ST_SUCCESS) begin
                        set_sticky_s = 1'b1;
                        sticky_val_s = resp_st_s;
                    end else begin
                        set_sticky_s = 1'b0;
                    end
                end else if (timeout_s) begin
                    state_s      = RSP;
                    rsp_status_s = ST_ERR;
                    rsp_data_s   = 32'h0000_0000;
                    set_sticky_s = 1'b1;
                    sticky_val_s = ST_ERR;
                end else begin
                    state_s = WAIT;
                end
            end
            RSP: begin
                if (rsp_ready_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = RSP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        // First error wins, and a new error beats a same-cycle dmireset.
        if (set_sticky_s && (dmistat_r == ST_SUCCESS)) begin
            dmistat_s = sticky_val_s;
        end else if (dmireset_i) begin
            dmistat_s = ST_SUCCESS;
        end else begin
            dmistat_s = dmistat_r;
        end
    end

    // State and datapath registers; dmihardreset acts as a synchronous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= IDLE;
            addr_r       <= 7'h00;
            op_r         <= 2'd0;
            wdata_r      <= 32'h0000_0000;
            rdata_r      <= 32'h0000_0000;
            rsp_data_r   <= 32'h0000_0000;
            rsp_status_r <= 2'd0;
            dmistat_r    <= 2'd0;
            cnt_r        <= {CntW{1'b0}};
        end else if (dmihardreset_i) begin
            state_r      <= IDLE;
            addr_r       <= 7'h00;
            op_r         <= 2'd0;
            wdata_r      <= 32'h0000_0000;
            rdata_r      <= 32'h0000_0000;
            rsp_data_r   <= 32'h0000_0000;
            rsp_status_r <= 2'd0;
            dmistat_r    <= 2'd0;
            cnt_r        <= {CntW{1'b0}};
        end else begin
            state_r      <= state_s;
            rdata_r      <= rdata_s;
            rsp_data_r   <= rsp_data_s;
            rsp_status_r <= rsp_status_s;
            dmistat_r    <= dmistat_s;
            cnt_r        <= cnt_s;
            if (latch_s) begin
                addr_r  <= cmd_addr_i;
                op_r    <= cmd_op_i;
                wdata_r <= cmd_data_i;
            end
        end
    end

    assign cmd_ready_o      = (state_r == IDLE);
    assign busy_o           = (state_r != IDLE);
    assign rsp_valid_o      = (state_r == RSP);
    assign rsp_data_o       = rsp_data_r;
    assign rsp_status_o     = rsp_status_r;
    assign dmi_req_valid_o  = (state_r == REQ);
    assign dmi_req_o        = {addr_r, op_r, wdata_r};
    assign dmi_resp_ready_o = (state_r == WAIT) || (state_r == IDLE);
    assign dmistat_o        = dmistat_r;

endmodule

// File: tb/tb_dm_dmi_host.sv
// Scoreboard bench for dm_dmi_host with a behavioural debug-module responder.
module tb_dm_dmi_host;

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [6:0]  cmd_addr;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_status;
    logic        dmi_req_valid, dmi_req_ready;
    logic [40:0] dmi_req;
    logic        dmi_resp_valid, dmi_resp_ready;
    logic [33:0] dmi_resp;
    logic        dmireset, dmihardreset;
    logic [1:0]  dmistat;
    logic        busy;

    logic        dmireset_main;
    logic        dm_rst_on_resp;
    logic        dm_ready_en;
    logic [33:0] dm_resp_val;
    int          dm_lat;
    int          dm_req_cnt = 0;
    logic [40:0] dm_last_req = 41'd0;

    int          checks = 0;
    int          failures = 0;
    logic [33:0] exp_q[$];

    assign dmireset      = dmireset_main | (dm_rst_on_resp & dmi_resp_valid);
    assign dmi_req_ready = dm_ready_en;

    dm_dmi_host #(.TimeoutCycles(4)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .cmd_valid_i      (cmd_valid),
        .cmd_ready_o      (cmd_ready),
        .cmd_addr_i       (cmd_addr),
        .cmd_op_i         (cmd_op),
        .cmd_data_i       (cmd_data),
        .rsp_valid_o      (rsp_valid),
        .rsp_ready_i      (rsp_ready),
        .rsp_data_o       (rsp_data),
        .rsp_status_o     (rsp_status),
        .dmi_req_valid_o  (dmi_req_valid),
        .dmi_req_ready_i  (dmi_req_ready),
        .dmi_req_o        (dmi_req),
        .dmi_resp_valid_i (dmi_resp_valid),
        .dmi_resp_ready_o (dmi_resp_ready),
        .dmi_resp_i       (dmi_resp),
        .dmireset_i       (dmireset),
        .dmihardreset_i   (dmihardreset),
        .dmistat_o        (dmistat),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Debug-module model: accepts requests while enabled, answers dm_lat edges after the handshake.
    initial begin
        bit          hs, take, pending;
        int          wait_c;
        logic [40:0] snap;
        logic [33:0] resp_hold;
        dmi_resp_valid = 1'b0;
        dmi_resp       = 34'd0;
        pending        = 1'b0;
        wait_c         = 0;
        resp_hold      = 34'd0;
        forever begin
            @(negedge clk);
            hs   = dmi_req_valid && dmi_req_ready;
            take = dmi_resp_valid && dmi_resp_ready;
            snap = dmi_req;
            @(posedge clk);
            #1;
            if (take) dmi_resp_valid = 1'b0;
            if (pending) begin
                wait_c--;
                if (wait_c <= 0) begin
                    dmi_resp_valid = 1'b1;
                    dmi_resp       = resp_hold;
                    pending        = 1'b0;
                end
            end
            if (hs) begin
                dm_req_cnt++;
                dm_last_req = snap;
                resp_hold   = dm_resp_val;
                wait_c      = dm_lat - 1;
                pending     = 1'b1;
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data);
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_valid = 1'b1;
        check_eq("cmd_ready_at_issue", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic collect(input int exp_lat, input int hold);
        int          k;
        logic [31:0] d0;
        logic [1:0]  s0;
        logic [33:0] exp;
        k = 0;
        while (!rsp_valid && k < 30) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq("rsp_seen", 64'(rsp_valid), 64'd1);
        if (exp_lat >= 0) check_eq("rsp_latency", 64'(k), 64'(exp_lat));
        d0 = rsp_data;
        s0 = rsp_status;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_eq("hold_valid", 64'(rsp_valid), 64'd1);
            check_eq("hold_data", 64'(rsp_data), 64'(d0));
            check_eq("hold_status", 64'(rsp_status), 64'(s0));
            check_eq("hold_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        check_eq("sb_depth", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check_eq("rsp_status", 64'(rsp_status), 64'(exp[33:32]));
            check_eq("rsp_data", 64'(rsp_data), 64'(exp[31:0]));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check_eq("rsp_released", 64'(rsp_valid), 64'd0);
        check_eq("idle_after_rsp", 64'(cmd_ready), 64'd1);
    endtask

    task automatic run_txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                           input logic [1:0] exp_st, input logic [31:0] exp_data,
                           input int exp_lat, input int hold);
        exp_q.push_back({exp_st, exp_data});
        issue(op, addr, data);
        collect(exp_lat, hold);
    endtask

    task automatic pulse_dmireset();
        dmireset_main = 1'b1;
        @(posedge clk);
        #1;
        dmireset_main = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst            = 1'b1;
        cmd_valid      = 1'b0;
        cmd_op         = 2'd0;
        cmd_addr       = 7'd0;
        cmd_data       = 32'd0;
        rsp_ready      = 1'b0;
        dmireset_main  = 1'b0;
        dmihardreset   = 1'b0;
        dm_ready_en    = 1'b1;
        dm_rst_on_resp = 1'b0;
        dm_resp_val    = 34'd0;
        dm_lat         = 3;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_req_valid", 64'(dmi_req_valid), 64'd0);
        check_eq("rst_dmistat", 64'(dmistat), 64'd0);
        check_eq("rst_rsp_data", 64'(rsp_data), 64'd0);
        check_eq("rst_dmi_req", 64'(dmi_req), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Plain READ
        base = dm_req_cnt;
        dm_resp_val = {32'hDEAD_BEEF, 2'd0};
        run_txn(OP_READ, 7'h11, 32'h0, 2'd0, 32'hDEAD_BEEF, 4, 0);
        check_eq("read_req_cnt", 64'(dm_req_cnt), 64'(base + 1));
        check_eq("read_req_addr_op", 64'(dm_last_req[40:32]), 64'({7'h11, 2'd1}));
        check_eq("read_dmistat", 64'(dmistat), 64'd0);

        // BUSY response becomes sticky and blocks the next command
        dm_resp_val = {32'h0, 2'd3};
        run_txn(OP_WRITE, 7'h10, 32'h1, 2'd3, 32'h0, -1, 0);
        check_eq("write_req", 64'(dm_last_req), 64'({7'h10, 2'd2, 32'h1}));
        check_eq("busy_sticky", 64'(dmistat), 64'd3);
        base = dm_req_cnt;
        run_txn(OP_READ, 7'h11, 32'h0, 2'd3, 32'h0, 0, 0);
        check_eq("sticky_no_req", 64'(dm_req_cnt), 64'(base));
        pulse_dmireset();
        check_eq("dmireset_clears", 64'(dmistat), 64'd0);
        dm_resp_val = {32'h0000_1234, 2'd0};
        run_txn(OP_READ, 7'h05, 32'h0, 2'd0, 32'h0000_1234, 4, 0);
        check_eq("after_clear_req", 64'(dm_req_cnt), 64'(base + 1));

        // NOP returns last read data; reserved op flags ERR
        run_txn(OP_NOP, 7'h00, 32'h0, 2'd0, 32'h0000_1234, 0, 0);
        base = dm_req_cnt;
        run_txn(OP_RSVD, 7'h02, 32'h0, 2'd2, 32'h0, 0, 0);
        check_eq("rsvd_dmistat", 64'(dmistat), 64'd2);
        check_eq("rsvd_no_req", 64'(dm_req_cnt), 64'(base));
        pulse_dmireset();

        // Timeout with the DM never ready
        dm_ready_en = 1'b0;
        base = dm_req_cnt;
        run_txn(OP_READ, 7'h20, 32'h0, 2'd2, 32'h0, 5, 0);
        check_eq("timeout_dmistat", 64'(dmistat), 64'd2);
        check_eq("timeout_no_hs", 64'(dm_req_cnt), 64'(base));
        dm_ready_en = 1'b1;
        pulse_dmireset();

        // Host back-pressure on the response
        dm_resp_val = {32'hCAFE_F00D, 2'd0};
        run_txn(OP_READ, 7'h03, 32'h0, 2'd0, 32'hCAFE_F00D, 4, 5);

        // Hard reset while waiting; the late DM response must be swallowed
        base = dm_req_cnt;
        dm_resp_val = {32'h5555_AAAA, 2'd0};
        issue(OP_READ, 7'h07, 32'h0);
        @(posedge clk);
        #1;
        check_eq("in_wait_busy", 64'(busy), 64'd1);
        dmihardreset = 1'b1;
        @(posedge clk);
        #1;
        dmihardreset = 1'b0;
        check_eq("hard_idle", 64'(cmd_ready), 64'd1);
        check_eq("hard_rsp_valid", 64'(rsp_valid), 64'd0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check_eq("late_rsp_dropped", 64'(rsp_valid), 64'd0);
        check_eq("late_rsp_idle", 64'(busy), 64'd0);
        check_eq("late_rsp_consumed", 64'(dmi_resp_valid), 64'd0);
        check_eq("hard_req_cnt", 64'(dm_req_cnt), 64'(base + 1));
        run_txn(OP_NOP, 7'h00, 32'h0, 2'd0, 32'h0, 0, 0);

        // dmireset coinciding with an ERR response: the error wins
        dm_resp_val = {32'h0, 2'd2};
        dm_rst_on_resp = 1'b1;
        run_txn(OP_READ, 7'h12, 32'h0, 2'd2, 32'h0, 4, 0);
        dm_rst_on_resp = 1'b0;
        check_eq("simul_dmistat", 64'(dmistat), 64'd2);
        pulse_dmireset();
        check_eq("simul_cleared", 64'(dmistat), 64'd0);

        // Reset in the middle of a request
        dm_ready_en = 1'b0;
        base = dm_req_cnt;
        issue(OP_READ, 7'h15, 32'h0);
        check_eq("mid_req_valid", 64'(dmi_req_valid), 64'd1);
        rst = 1'b1;
        #1;
        check_eq("rst_drops_req", 64'(dmi_req_valid), 64'd0);
        check_eq("rst_cmd_ready_mid", 64'(cmd_ready), 64'd1);
        dm_ready_en = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_no_hs", 64'(dm_req_cnt), 64'(base));
        check_eq("rst_not_busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
